// File: rtl/synapse_arbiter_if.sv
// Bundle of the synapse arbiter handshake, weight-write and status signals.
//
// Parameters:
//   N_IN      - number of presynaptic spike channels
//   DATA_SIZE - weight / data_out width
//
// Signals:
//   req_in   [N_IN]      4-phase spike requests from presynaptic neurons
//   ack_in   [N_IN]      4-phase acknowledges back to presynaptic neurons
//   data_out [DATA_SIZE] weight sent to the downstream neuron
//   req_out              4-phase request to the downstream neuron
//   ack_out              4-phase acknowledge from the downstream neuron
//   wr_en                weight write strobe
//   wr_addr  [AW]        weight index
//   wr_data  [DATA_SIZE] weight value
//   busy                 arbiter is not idle
//
// Modports: slave = arbiter side, master = environment side.
interface synapse_arbiter_if #(
    parameter int unsigned N_IN      = 4,
    parameter int unsigned DATA_SIZE = 10
);
    localparam int unsigned AW = (N_IN > 1) ? $clog2(N_IN) : 1;

    logic [N_IN-1:0]      req_in;
    logic [N_IN-1:0]      ack_in;
    logic [DATA_SIZE-1:0] data_out;
    logic                 req_out;
    logic                 ack_out;
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [DATA_SIZE-1:0] wr_data;
    logic                 busy;

    modport slave (
        input  req_in,
        input  ack_out,
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        output ack_in,
        output data_out,
        output req_out,
        output busy
    );

    modport master (
        output req_in,
        output ack_out,
        output wr_en,
        output wr_addr,
        output wr_data,
        input  ack_in,
        input  data_out,
        input  req_out,
        input  busy
    );
endinterface

// File: rtl/synapse_arbiter.sv
// Synapse arbiter: round-robin arbitration of N_IN 4-phase spike requests onto a single
// 4-phase link to a downstream neuron, forwarding the per-channel weight on data_out.
//
// Parameters:
//   N_IN        - number of presynaptic spike channels
//   DATA_SIZE   - weight / data_out width
//   WEIGHT_INIT - reset value of every weight register
//
// Ports:
//   clk   - system clock, all state on rising edge
//   rst_n - asynchronous active-low reset
//   bus   - synapse_arbiter_if.slave (req_in/ack_in, req_out/ack_out/data_out,
//           wr_en/wr_addr/wr_data weight write port, busy)
//
// Build option: define SYNAPSE_SYNC_EN to pass req_in and ack_out through 2-flop
// synchronisers (adds 2 clocks to each handshake latency). Without it both are treated
// as synchronous to clk and sampled directly.
module synapse_arbiter #(
    parameter int unsigned N_IN        = 4,
    parameter int unsigned DATA_SIZE   = 10,
    parameter int unsigned WEIGHT_INIT = 0
) (
    input logic              clk,
    input logic              rst_n,
    synapse_arbiter_if.slave bus
);
    localparam int unsigned          AW       = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [AW-1:0]        LAST_IDX = AW'(N_IN - 1);
    localparam logic [DATA_SIZE-1:0] W_INIT   = DATA_SIZE'(WEIGHT_INIT);

    typedef enum logic [2:0] {StIdle, StLoad, StReq, StRtz, StAck} state_e;

    state_e state_q, state_d;

    logic [N_IN-1:0] req_s;
    logic            ack_s;

`ifdef SYNAPSE_SYNC_EN
    logic [N_IN-1:0] req_meta_q, req_sync_q;
    logic            ack_meta_q, ack_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_meta_q <= '0;
            req_sync_q <= '0;
            ack_meta_q <= 1'b0;
            ack_sync_q <= 1'b0;
        end else begin
            req_meta_q <= bus.req_in;
            req_sync_q <= req_meta_q;
            ack_meta_q <= bus.ack_out;
            ack_sync_q <= ack_meta_q;
        end
    end

    assign req_s = req_sync_q;
    assign ack_s = ack_sync_q;
`else
    assign req_s = bus.req_in;
    assign ack_s = bus.ack_out;
`endif

    logic [DATA_SIZE-1:0] weight_q [N_IN];
    logic [DATA_SIZE-1:0] sel_q;
    logic [DATA_SIZE-1:0] data_out_q, data_out_d;
    logic [AW-1:0]        grant_q, grant_d;
    logic [AW-1:0]        last_grant_q;
    logic [AW-1:0]        cand;
    logic                 found;
    logic                 req_out_q, req_out_d;
    logic [N_IN-1:0]      ack_in_q, ack_in_d;
    logic [N_IN-1:0]      pending;

    // Weight registers; addresses at or beyond N_IN match no register and are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_IN; i++) weight_q[i] <= W_INIT;
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (bus.wr_en && bus.wr_addr == AW'(i)) weight_q[i] <= bus.wr_data;
            end
        end
    end

    // Round-robin search starting at last_grant+1, wrapping at N_IN-1.
    assign pending = req_s & ~ack_in_q;

    always_comb begin
        cand    = last_grant_q;
        found   = 1'b0;
        grant_d = grant_q;
        for (int i = 0; i < N_IN; i++) begin
            cand = (cand == LAST_IDX) ? '0 : cand + AW'(1);
            if (!found && pending[cand]) begin
                found   = 1'b1;
                grant_d = cand;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (found) state_d = StLoad;
            StLoad:  state_d = StReq;
            // Only accept ack_out once our own req_out has actually been seen high.
            StReq:   if (req_out_q && ack_s) state_d = StRtz;
            StRtz:   if (!ack_s) state_d = StAck;
            StAck:   if (!req_s[grant_q]) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        data_out_d = data_out_q;
        req_out_d  = 1'b0;
        ack_in_d   = '0;
        if (state_q == StLoad) data_out_d = sel_q;
        if (state_q == StReq && state_d == StReq) req_out_d = 1'b1;
        if (state_d == StAck) ack_in_d[grant_q] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q      <= '0;
            last_grant_q <= LAST_IDX;
            sel_q        <= '0;
            data_out_q   <= '0;
            req_out_q    <= 1'b0;
            ack_in_q     <= '0;
        end else begin
            // Weight is captured on the grant edge so a same-edge write is not seen,
            // and later writes to this index cannot disturb the event in flight.
            if (state_q == StIdle && found) begin
                grant_q <= grant_d;
                sel_q   <= weight_q[grant_d];
            end
            if (state_q == StAck && state_d == StIdle) last_grant_q <= grant_q;
            data_out_q <= data_out_d;
            req_out_q  <= req_out_d;
            ack_in_q   <= ack_in_d;
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.req_out  = req_out_q;
    assign bus.ack_in   = ack_in_q;
    assign bus.busy     = (state_q != StIdle);
endmodule

// File: tb/tb_synapse_arbiter.sv
// Directed bench for synapse_arbiter. A presynaptic requester model and a downstream
// responder model run once per clock (at the falling edge). Expected weights and granted
// channels are queued when stimulus is launched and checked when req_out / ack_in rise.
// A second 3-channel instance exercises out-of-range weight addresses, which a 2-bit
// address on the 4-channel instance cannot express.
module tb_synapse_arbiter;
    localparam int unsigned N_IN    = 4;
    localparam int unsigned N3      = 3;
    localparam int unsigned DW      = 10;
    localparam int unsigned AW      = 2;
    localparam int unsigned W_INIT  = 'h05A;
    localparam int unsigned W_INIT3 = 9;
`ifdef SYNAPSE_SYNC_EN
    localparam int EXP_LAT = 5;
`else
    localparam int EXP_LAT = 3;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    synapse_arbiter_if #(.N_IN(N_IN), .DATA_SIZE(DW)) bus ();
    synapse_arbiter_if #(.N_IN(N3), .DATA_SIZE(DW)) bus3 ();

    synapse_arbiter #(.N_IN(N_IN), .DATA_SIZE(DW), .WEIGHT_INIT(W_INIT)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    synapse_arbiter #(.N_IN(N3), .DATA_SIZE(DW), .WEIGHT_INIT(W_INIT3)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    int total = 0;
    int bad   = 0;

    logic [DW-1:0]   exp_data_q [$];
    int              exp_chan_q [$];
    logic [DW-1:0]   exp3_q [$];
    logic [N_IN-1:0] want  = '0;
    logic            rearm = 1'b0;
    logic [N3-1:0]   want3 = '0;
    logic            req_out_prev  = 1'b0;
    logic            req_out3_prev = 1'b0;
    logic [N_IN-1:0] ack_prev = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock of the environment: scoreboard, downstream responder, requesters.
    task automatic step();
        @(negedge clk);
        if (bus.req_out && !req_out_prev) begin
            if (exp_data_q.size() == 0) check("unexpected_req_out", bus.req_out, 0);
            else check("data_out", bus.data_out, exp_data_q.pop_front());
        end
        if (bus.ack_in != '0 && ack_prev == '0) begin
            if (exp_chan_q.size() == 0) check("unexpected_ack", bus.ack_in, 0);
            else check("ack_chan", bus.ack_in, 32'(1) << exp_chan_q.pop_front());
        end
        check("ack_onehot", $countones(bus.ack_in) <= 1, 1);
        if (bus.req_out) check("ack_during_req", bus.ack_in, 0);
        if (bus3.req_out && !req_out3_prev) begin
            if (exp3_q.size() == 0) check("unexpected_req_out3", bus3.req_out, 0);
            else check("data_out3", bus3.data_out, exp3_q.pop_front());
        end
        req_out_prev  = bus.req_out;
        req_out3_prev = bus3.req_out;
        ack_prev      = bus.ack_in;
        bus.ack_out   = bus.req_out;
        bus3.ack_out  = bus3.req_out;
        for (int i = 0; i < N_IN; i++) begin
            if (bus.ack_in[i]) begin
                bus.req_in[i] = 1'b0;
                if (!rearm) want[i] = 1'b0;
            end else begin
                bus.req_in[i] = want[i];
            end
        end
        for (int i = 0; i < N3; i++) begin
            if (bus3.ack_in[i]) begin
                bus3.req_in[i] = 1'b0;
                want3[i] = 1'b0;
            end else begin
                bus3.req_in[i] = want3[i];
            end
        end
    endtask

    task automatic wait_idle(input string tag, input int max);
        int  n = 0;
        logic done = 1'b0;
        while (!done && n < max) begin
            step();
            n++;
            done = !bus.busy && bus.req_in == '0 && want == '0 &&
                   !bus3.busy && bus3.req_in == '0 && want3 == '0;
        end
        check({tag, "_idle"}, done, 1);
    endtask

    task automatic step_until_req_out(input logic level, input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (bus.req_out !== level && n < 40);
        check(tag, bus.req_out, level);
    endtask

    task automatic write_w(input int addr, input logic [DW-1:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = AW'(addr);
        bus.wr_data = data;
        step();
        bus.wr_en   = 1'b0;
    endtask

    task automatic write_w3(input int addr, input logic [DW-1:0] data);
        bus3.wr_en   = 1'b1;
        bus3.wr_addr = AW'(addr);
        bus3.wr_data = data;
        step();
        bus3.wr_en   = 1'b0;
    endtask

    initial begin
        int n;
        logic [DW-1:0] wts [4];
        wts = '{10'd1, 10'd2, 10'd3, 10'd4};
        bus.req_in  = '0;
        bus.ack_out = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus3.req_in  = '0;
        bus3.ack_out = 1'b0;
        bus3.wr_en   = 1'b0;
        bus3.wr_addr = '0;
        bus3.wr_data = '0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_ack_in", bus.ack_in, 0);
        check("rst_req_out", bus.req_out, 0);
        check("rst_data_out", bus.data_out, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_busy3", bus3.busy, 0);
        rst_n = 1'b1;

        // All channels requesting continuously: 1,2,3,4,1 starting at channel 0
        for (int i = 0; i < 4; i++) write_w(i, wts[i]);
        for (int i = 0; i < 5; i++) begin
            exp_data_q.push_back(wts[i % 4]);
            exp_chan_q.push_back(i % 4);
        end
        rearm = 1'b1;
        want  = '1;
        n = 0;
        while (exp_data_q.size() != 0 && n < 400) begin
            step();
            n++;
        end
        check("rr_events_seen", exp_data_q.size(), 0);
        want  = '0;
        rearm = 1'b0;
        wait_idle("rr", 100);

        // Single 4-phase event on channel 2 and its req_in-to-req_out latency
        write_w(2, 10'h0A5);
        exp_data_q.push_back(10'h0A5);
        exp_chan_q.push_back(2);
        want[2] = 1'b1;
        bus.req_in[2] = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.req_out && n < 20);
        check("latency", n, EXP_LAT);
        wait_idle("single", 100);

        // Write to the granted index mid-event is not seen until the next event
        write_w(1, 10'd3);
        exp_data_q.push_back(10'd3);
        exp_chan_q.push_back(1);
        want[1] = 1'b1;
        step_until_req_out(1'b1, "ch1_req_high");
        write_w(1, 10'd7);
        check("hold_data", bus.data_out, 3);
        wait_idle("ch1_old", 100);
        exp_data_q.push_back(10'd7);
        exp_chan_q.push_back(1);
        want[1] = 1'b1;
        wait_idle("ch1_new", 100);

        // Reset in RTZ with req_in[0] held; channel 0 served again with WEIGHT_INIT
        exp_data_q.push_back(wts[0]);
        exp_chan_q.push_back(0);
        want[0] = 1'b1;
        step_until_req_out(1'b1, "rtz_req_high");
        step_until_req_out(1'b0, "rtz_req_low");
        check("rtz_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ack_in", bus.ack_in, 0);
        check("mid_rst_req_out", bus.req_out, 0);
        check("mid_rst_data_out", bus.data_out, 0);
        check("mid_rst_busy", bus.busy, 0);
        exp_chan_q.delete();
        bus.ack_out = 1'b0;
        req_out_prev = 1'b0;
        ack_prev = '0;
        repeat (2) @(negedge clk);
        check("rst_held_req", bus.req_in[0], 1);
        rst_n = 1'b1;
        exp_data_q.push_back(10'(W_INIT));
        exp_chan_q.push_back(0);
        wait_idle("reserve", 100);

        // Out-of-range address on the 3-channel instance changes no weight
        write_w3(3, 10'h3FF);
        write_w3(1, 10'h011);
        exp3_q.push_back(10'(W_INIT3));
        exp3_q.push_back(10'h011);
        exp3_q.push_back(10'(W_INIT3));
        want3 = '1;
        wait_idle("oor", 200);

        check("sb_data_empty", exp_data_q.size(), 0);
        check("sb_chan_empty", exp_chan_q.size(), 0);
        check("sb3_empty", exp3_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
